// File: rtl/cache_pkg.sv
// Shared encodings for the set-associative MESI cache memory: line states,
// L1/bus/snoop opcodes and response codes, and the request FSM states.
package cache_pkg;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_e;

  localparam logic [2:0] CDREQ_RD  = 3'd0;
  localparam logic [2:0] CDREQ_RFO = 3'd1;
  localparam logic [2:0] CDREQ_MD  = 3'd2;
  localparam logic [2:0] CDREQ_WB  = 3'd3;

  localparam logic [2:0] SDREQ_RD  = 3'd0;
  localparam logic [2:0] SDREQ_RFO = 3'd1;
  localparam logic [2:0] SDREQ_INV = 3'd2;
  localparam logic [2:0] SDREQ_WB  = 3'd3;

  localparam logic [1:0] SURSP_DATA_S = 2'd0;
  localparam logic [1:0] SURSP_DATA_E = 2'd1;
  localparam logic [1:0] SURSP_ACK    = 2'd2;

  localparam logic [1:0] SNP_RD  = 2'd0;
  localparam logic [1:0] SNP_INV = 2'd1;

  localparam logic [1:0] SDRSP_MISS      = 2'd0;
  localparam logic [1:0] SDRSP_HIT_CLEAN = 2'd1;
  localparam logic [1:0] SDRSP_HIT_DIRTY = 2'd2;

  localparam logic [1:0] CURSP_OKAY   = 2'd0;
  localparam logic [1:0] CURSP_DATA_S = 2'd1;
  localparam logic [1:0] CURSP_DATA_E = 2'd2;
  localparam logic [1:0] CURSP_DATA_M = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOOKUP, ST_VICT_WB, ST_FILL_REQ,
    ST_WAIT_FILL, ST_UPG_REQ, ST_WAIT_ACK, ST_RSP
  } req_st_e;

  // L1 response code that reports a valid line's current state.
  function automatic logic [1:0] state_rsp(input mesi_e s);
    return (s == MESI_S) ? CURSP_DATA_S : (s == MESI_E) ? CURSP_DATA_E : CURSP_DATA_M;
  endfunction

endpackage

// File: rtl/cache_way_sel.sv
// Combinational tag match across one set plus victim choice: lowest Invalid
// way first, otherwise the set's round-robin pointer.
module cache_way_sel
  import cache_pkg::*;
#(
  parameter int NUM_WAY = 4,
  parameter int TAG_W   = 50,
  parameter int WAY_W   = 2
) (
  input  mesi_e            states_i [NUM_WAY],
  input  logic [TAG_W-1:0] tags_i   [NUM_WAY],
  input  logic [TAG_W-1:0] tag_i,
  input  logic [WAY_W-1:0] rr_i,
  output logic             hit_o,
  output logic             multi_o,
  output logic [WAY_W-1:0] hit_way_o,
  output logic [WAY_W-1:0] vict_way_o
);

  logic found_inv;

  always_comb begin
    hit_o      = 1'b0;
    multi_o    = 1'b0;
    hit_way_o  = '0;
    vict_way_o = rr_i;
    found_inv  = 1'b0;
    for (int w = 0; w < NUM_WAY; w++) begin
      if (states_i[w] != MESI_I && tags_i[w] == tag_i) begin
        multi_o   = multi_o | hit_o;
        hit_o     = 1'b1;
        hit_way_o = WAY_W'(w);
      end
      if (states_i[w] == MESI_I && !found_inv) begin
        found_inv  = 1'b1;
        vict_way_o = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/cache_mem_sa.sv
// NUM_WAY-way set-associative MESI cache memory: blocking L1 request FSM with
// victim writeback, S->M upgrade, and snoop servicing while waiting on the bus.
module cache_mem_sa
  import cache_pkg::*;
#(
  parameter int PADDR_WIDTH = 64,
  parameter int BLK_WIDTH   = 512,
  parameter int NUM_SET     = 256,
  parameter int NUM_WAY     = 4,
  parameter int SADDR_WIDTH = PADDR_WIDTH - $clog2(BLK_WIDTH/8)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cdreq_valid,
  output logic                   cdreq_ready,
  input  logic [2:0]             cdreq_op,
  input  logic [SADDR_WIDTH-1:0] cdreq_addr,
  input  logic [BLK_WIDTH-1:0]   cdreq_data,
  output logic                   cursp_valid,
  input  logic                   cursp_ready,
  output logic [1:0]             cursp_rsp,
  output logic [BLK_WIDTH-1:0]   cursp_data,
  output logic                   sdreq_valid,
  input  logic                   sdreq_ready,
  output logic [2:0]             sdreq_op,
  output logic [SADDR_WIDTH-1:0] sdreq_addr,
  output logic [BLK_WIDTH-1:0]   sdreq_data,
  input  logic                   sursp_valid,
  output logic                   sursp_ready,
  input  logic [1:0]             sursp_rsp,
  input  logic [BLK_WIDTH-1:0]   sursp_data,
  input  logic                   sureq_valid,
  output logic                   sureq_ready,
  input  logic [1:0]             sureq_op,
  input  logic [SADDR_WIDTH-1:0] sureq_addr,
  output logic                   sdrsp_valid,
  input  logic                   sdrsp_ready,
  output logic [1:0]             sdrsp_rsp,
  output logic [BLK_WIDTH-1:0]   sdrsp_data
);

  localparam int IDX_W = $clog2(NUM_SET);
  localparam int TAG_W = SADDR_WIDTH - IDX_W;
  localparam int WAY_W = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1;

  req_st_e                req_st_q;
  logic [2:0]             op_q;
  logic [SADDR_WIDTH-1:0] addr_q;
  logic [BLK_WIDTH-1:0]   wdata_q;
  logic [WAY_W-1:0]       way_q;
  mesi_e                  state_q [NUM_SET][NUM_WAY];
  logic [TAG_W-1:0]       tag_q   [NUM_SET][NUM_WAY];
  logic [BLK_WIDTH-1:0]   data_q  [NUM_SET][NUM_WAY];
  logic [WAY_W-1:0]       rr_q    [NUM_SET];

  logic                   sdreq_valid_q, cursp_valid_q, snp_vld_q;
  logic [2:0]             sdreq_op_q;
  logic [SADDR_WIDTH-1:0] sdreq_addr_q;
  logic [BLK_WIDTH-1:0]   sdreq_data_q, cursp_data_q, snp_data_q;
  logic [1:0]             cursp_rsp_q, snp_rsp_q;

  logic [IDX_W-1:0]       ridx, lk_idx;
  logic [SADDR_WIDTH-1:0] lk_addr;
  logic [TAG_W-1:0]       lk_tag;
  logic                   lk_hit, lk_multi, snp_hs, still_s;
  logic [WAY_W-1:0]       lk_hit_way, lk_vict_way, rr_nxt, wway;
  mesi_e                  lk_state, vict_state;
  logic [2:0]             fill_op;
  logic                   dwe, twe;
  logic [BLK_WIDTH-1:0]   wdata;

  // The lookup port serves the L1 request in LOOKUP and snoops otherwise;
  // snoops are never accepted in LOOKUP, so the two never collide.
  assign lk_addr    = (req_st_q == ST_LOOKUP) ? addr_q : sureq_addr;
  assign lk_idx     = lk_addr[IDX_W-1:0];
  assign lk_tag     = lk_addr[SADDR_WIDTH-1:IDX_W];
  assign ridx       = addr_q[IDX_W-1:0];
  assign lk_state   = state_q[lk_idx][lk_hit_way];
  assign vict_state = state_q[lk_idx][lk_vict_way];
  assign rr_nxt     = (rr_q[ridx] == WAY_W'(NUM_WAY-1)) ? '0 : rr_q[ridx] + 1'b1;
  assign fill_op    = (op_q == CDREQ_RD) ? SDREQ_RD : SDREQ_RFO;

  cache_way_sel #(.NUM_WAY(NUM_WAY), .TAG_W(TAG_W), .WAY_W(WAY_W)) u_way_sel (
    .states_i  (state_q[lk_idx]),
    .tags_i    (tag_q[lk_idx]),
    .tag_i     (lk_tag),
    .rr_i      (rr_q[lk_idx]),
    .hit_o     (lk_hit),
    .multi_o   (lk_multi),
    .hit_way_o (lk_hit_way),
    .vict_way_o(lk_vict_way)
  );

  assign cdreq_ready = !rst && req_st_q == ST_IDLE && !sureq_valid;
  assign sursp_ready = !rst && (req_st_q == ST_WAIT_FILL || req_st_q == ST_WAIT_ACK);
  assign sureq_ready = !rst && !snp_vld_q &&
                       (req_st_q == ST_IDLE || req_st_q == ST_WAIT_FILL || req_st_q == ST_WAIT_ACK);
  assign snp_hs      = sureq_valid && sureq_ready;

  // An upgrade only completes if the S copy survived, including a snoop
  // invalidating it in the very cycle the ACK arrives.
  assign still_s = state_q[ridx][way_q] == MESI_S &&
                   !(snp_hs && lk_hit && lk_idx == ridx && lk_hit_way == way_q && sureq_op == SNP_INV);

  always_comb begin
    dwe   = 1'b0;
    twe   = 1'b0;
    wway  = way_q;
    wdata = wdata_q;
    if (!rst) begin
      case (req_st_q)
        ST_LOOKUP:
          if (lk_hit) begin
            wway = lk_hit_way;
            dwe  = (op_q == CDREQ_WB) || (op_q == CDREQ_MD && lk_state != MESI_S);
          end else if (op_q == CDREQ_WB && vict_state != MESI_M) begin
            wway = lk_vict_way;
            dwe  = 1'b1;
            twe  = 1'b1;
          end
        ST_VICT_WB: begin
          dwe = sdreq_ready && op_q == CDREQ_WB;
          twe = sdreq_ready && op_q == CDREQ_WB;
        end
        ST_WAIT_FILL:
          if (sursp_valid) begin
            dwe = 1'b1;
            twe = 1'b1;
            if (op_q != CDREQ_MD) wdata = sursp_data;
          end
        ST_WAIT_ACK: dwe = sursp_valid && still_s && op_q == CDREQ_MD;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (dwe) data_q[ridx][wway] <= wdata;
    if (twe) tag_q[ridx][wway]  <= addr_q[SADDR_WIDTH-1:IDX_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_st_q      <= ST_IDLE;
      sdreq_valid_q <= 1'b0;
      cursp_valid_q <= 1'b0;
      snp_vld_q     <= 1'b0;
      for (int s = 0; s < NUM_SET; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < NUM_WAY; w++) state_q[s][w] <= MESI_I;
      end
    end else begin
      assert (!lk_multi) else $fatal(1, "cache_mem_sa: multiple ways match one tag");
      if (sdrsp_valid && sdrsp_ready) snp_vld_q <= 1'b0;
      if (snp_hs) begin
        snp_vld_q  <= 1'b1;
        snp_rsp_q  <= SDRSP_MISS;
        snp_data_q <= '0;
        if (lk_hit) begin
          snp_rsp_q <= (lk_state == MESI_M) ? SDRSP_HIT_DIRTY : SDRSP_HIT_CLEAN;
          if (lk_state == MESI_M) snp_data_q <= data_q[lk_idx][lk_hit_way];
          state_q[lk_idx][lk_hit_way] <= (sureq_op == SNP_INV) ? MESI_I : MESI_S;
        end
      end
      // Request updates come last so they own any line they share with a snoop.
      case (req_st_q)
        ST_IDLE:
          if (cdreq_valid && cdreq_ready) begin
            op_q     <= cdreq_op;
            addr_q   <= cdreq_addr;
            wdata_q  <= cdreq_data;
            req_st_q <= ST_LOOKUP;
          end
        ST_LOOKUP:
          if (lk_hit) begin
            way_q        <= lk_hit_way;
            cursp_data_q <= data_q[ridx][lk_hit_way];
            if (op_q == CDREQ_RD) begin
              cursp_rsp_q   <= state_rsp(lk_state);
              cursp_valid_q <= 1'b1;
              req_st_q      <= ST_RSP;
            end else if (op_q == CDREQ_WB) begin
              state_q[ridx][lk_hit_way] <= MESI_M;
              cursp_rsp_q   <= CURSP_OKAY;
              cursp_valid_q <= 1'b1;
              req_st_q      <= ST_RSP;
            end else if (lk_state == MESI_S) begin
              sdreq_valid_q <= 1'b1;
              sdreq_op_q    <= SDREQ_INV;
              sdreq_addr_q  <= addr_q;
              sdreq_data_q  <= '0;
              req_st_q      <= ST_UPG_REQ;
            end else begin
              state_q[ridx][lk_hit_way] <= MESI_M;
              if (op_q == CDREQ_MD) cursp_data_q <= wdata_q;
              cursp_rsp_q   <= CURSP_DATA_M;
              cursp_valid_q <= 1'b1;
              req_st_q      <= ST_RSP;
            end
          end else begin
            way_q      <= lk_vict_way;
            rr_q[ridx] <= rr_nxt;
            if (vict_state == MESI_M) begin
              sdreq_valid_q <= 1'b1;
              sdreq_op_q    <= SDREQ_WB;
              sdreq_addr_q  <= {tag_q[ridx][lk_vict_way], ridx};
              sdreq_data_q  <= data_q[ridx][lk_vict_way];
              req_st_q      <= ST_VICT_WB;
            end else if (op_q == CDREQ_WB) begin
              state_q[ridx][lk_vict_way] <= MESI_M;
              cursp_rsp_q   <= CURSP_OKAY;
              cursp_data_q  <= wdata_q;
              cursp_valid_q <= 1'b1;
              req_st_q      <= ST_RSP;
            end else begin
              state_q[ridx][lk_vict_way] <= MESI_I;
              sdreq_valid_q <= 1'b1;
              sdreq_op_q    <= fill_op;
              sdreq_addr_q  <= addr_q;
              sdreq_data_q  <= '0;
              req_st_q      <= ST_FILL_REQ;
            end
          end
        ST_VICT_WB:
          if (sdreq_ready) begin
            if (op_q == CDREQ_WB) begin
              state_q[ridx][way_q] <= MESI_M;
              sdreq_valid_q <= 1'b0;
              cursp_rsp_q   <= CURSP_OKAY;
              cursp_data_q  <= wdata_q;
              cursp_valid_q <= 1'b1;
              req_st_q      <= ST_RSP;
            end else begin
              state_q[ridx][way_q] <= MESI_I;
              sdreq_op_q   <= fill_op;
              sdreq_addr_q <= addr_q;
              sdreq_data_q <= '0;
              req_st_q     <= ST_FILL_REQ;
            end
          end
        ST_FILL_REQ, ST_UPG_REQ:
          if (sdreq_ready) begin
            sdreq_valid_q <= 1'b0;
            req_st_q      <= (req_st_q == ST_FILL_REQ) ? ST_WAIT_FILL : ST_WAIT_ACK;
          end
        ST_WAIT_FILL:
          if (sursp_valid) begin
            if (op_q == CDREQ_RD) begin
              state_q[ridx][way_q] <= (sursp_rsp == SURSP_DATA_E) ? MESI_E : MESI_S;
              cursp_rsp_q <= (sursp_rsp == SURSP_DATA_E) ? CURSP_DATA_E : CURSP_DATA_S;
            end else begin
              state_q[ridx][way_q] <= MESI_M;
              cursp_rsp_q <= CURSP_DATA_M;
            end
            cursp_data_q  <= (op_q == CDREQ_MD) ? wdata_q : sursp_data;
            cursp_valid_q <= 1'b1;
            req_st_q      <= ST_RSP;
          end
        ST_WAIT_ACK:
          if (sursp_valid) begin
            if (still_s) begin
              state_q[ridx][way_q] <= MESI_M;
              cursp_rsp_q   <= CURSP_DATA_M;
              cursp_data_q  <= (op_q == CDREQ_MD) ? wdata_q : data_q[ridx][way_q];
              cursp_valid_q <= 1'b1;
              req_st_q      <= ST_RSP;
            end else begin
              sdreq_valid_q <= 1'b1;
              sdreq_op_q    <= SDREQ_RFO;
              sdreq_addr_q  <= addr_q;
              sdreq_data_q  <= '0;
              req_st_q      <= ST_FILL_REQ;
            end
          end
        ST_RSP:
          if (cursp_ready) begin
            cursp_valid_q <= 1'b0;
            req_st_q      <= ST_IDLE;
          end
        default: req_st_q <= ST_IDLE;
      endcase
    end
  end

  assign cursp_valid = cursp_valid_q;
  assign cursp_rsp   = cursp_rsp_q;
  assign cursp_data  = cursp_data_q;
  assign sdreq_valid = sdreq_valid_q;
  assign sdreq_op    = sdreq_op_q;
  assign sdreq_addr  = sdreq_addr_q;
  assign sdreq_data  = sdreq_data_q;
  assign sdrsp_valid = snp_vld_q;
  assign sdrsp_rsp   = snp_rsp_q;
  assign sdrsp_data  = snp_data_q;

endmodule
